// File: rtl/digest_view_ctrl.sv
// Holds an MD5 digest and drives a scrollable 6-nibble seven-segment window.
// Buttons are synchronized and debounced; auto-scroll wraps, buttons saturate.
module digest_view_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SCROLL_PERIOD = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] digest_in,
  input  logic         digest_valid,
  output logic         digest_ready,
  input  logic         start,
  input  logic         left_shift,
  input  logic         right_shift,
  input  logic         auto_en,
  input  logic         clear,
  output logic [4:0]   offset,
  output logic [4:0]   seg5,
  output logic [4:0]   seg4,
  output logic [4:0]   seg3,
  output logic [4:0]   seg2,
  output logic [4:0]   seg1,
  output logic [4:0]   seg
);
  typedef enum logic [1:0] {IDLE, LOAD, SHOW} state_t;

  localparam logic [15:0] TERM = 16'(SCROLL_PERIOD - 1);
  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0] MAX_OFF = 5'd26;
  localparam logic [29:0] BLANK = {6{5'b10000}};

  state_t state, state_nxt;
  logic [127:0] digest, digest_nxt;
  logic [4:0] offset_nxt;
  logic [15:0] timer, timer_nxt;
  logic [29:0] segs, segs_nxt;
  logic xfer;

  // bit 1 = left, bit 0 = right
  logic [1:0] sync1, sync2, level, level_q, ev;
  logic [7:0] cnt [2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      level_q <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      sync1 <= {left_shift, right_shift};
      sync2 <= sync1;
      level_q <= level;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != level[i]) begin
          if (cnt[i] == DB_LAST) begin
            level[i] <= ~level[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 8'd1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign ev = level & ~level_q;
  assign digest_ready = (state != LOAD);
  assign xfer = digest_valid && digest_ready;

  function automatic logic [29:0] window(
    input logic [127:0] d,
    input logic [4:0] off
  );
    logic [29:0] w;
    logic [4:0] idx;
    w = '0;
    for (int j = 0; j < 6; j++) begin
      idx = 5'(26 + j) - off;
      w[j*5 +: 5] = {1'b0, d[{idx, 2'b00} +: 4]};
    end
    return w;
  endfunction

  always_comb begin
    state_nxt = state;
    digest_nxt = digest;
    offset_nxt = offset;
    timer_nxt = timer;
    segs_nxt = segs;
    unique case (state)
      IDLE: begin
        if (xfer) begin
          digest_nxt = digest_in;
          state_nxt = LOAD;
        end else if (clear) begin
          digest_nxt = '0;
          segs_nxt = BLANK;
        end
      end
      LOAD: begin
        offset_nxt = '0;
        timer_nxt = '0;
        segs_nxt = window(digest, 5'd0);
        state_nxt = SHOW;
      end
      SHOW: begin
        if (xfer) begin
          digest_nxt = digest_in;
          state_nxt = LOAD;
        end else if (clear) begin
          digest_nxt = '0;
          offset_nxt = '0;
          timer_nxt = '0;
          segs_nxt = BLANK;
          state_nxt = IDLE;
        end else if (start) begin
          if (ev != 2'b00) begin
            timer_nxt = '0;
            if (ev == 2'b01 && offset != MAX_OFF)
              offset_nxt = offset + 5'd1;
            else if (ev == 2'b10 && offset != 5'd0)
              offset_nxt = offset - 5'd1;
          end else if (auto_en) begin
            if (timer == TERM) begin
              timer_nxt = '0;
              offset_nxt = (offset == MAX_OFF) ? 5'd0 : offset + 5'd1;
            end else begin
              timer_nxt = timer + 16'd1;
            end
          end else begin
            timer_nxt = '0;
          end
          segs_nxt = window(digest, offset_nxt);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      digest <= '0;
      offset <= '0;
      timer <= '0;
      segs <= '0;
    end else begin
      state <= state_nxt;
      digest <= digest_nxt;
      offset <= offset_nxt;
      timer <= timer_nxt;
      segs <= segs_nxt;
    end
  end

  assign seg5 = segs[29:25];
  assign seg4 = segs[24:20];
  assign seg3 = segs[19:15];
  assign seg2 = segs[14:10];
  assign seg1 = segs[9:5];
  assign seg  = segs[4:0];
endmodule
